// File: rtl/uart_rx_intr_if.sv
// CPU-facing read port of the UART receiver: level interrupt request plus head-of-FIFO data.
// Handshake: irr is high while a byte is available and r_data holds it. The CPU takes that
// byte by raising ack. Only the ack rising edge pops one byte, so ack may stay high for any
// length. An ack raised while irr is low is ignored. The next byte, if any, appears the
// cycle after the pop.
interface uart_rx_intr_if;
    logic       irr;
    logic [7:0] r_data;
    logic       ack;

    modport master (output irr, output r_data, input ack);
    modport slave  (input irr, input r_data, output ack);
endinterface

// File: rtl/uart_rx_intr.sv
// 8N1 UART receiver with a small byte FIFO that raises irr while data is buffered.
// The FSM runs on the synchronised line only. Every sample is taken at a counter wrap point.
module uart_rx_intr #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_intr_if.master cpu,
    output logic           overrun,
    output logic           frame_err,
    output logic [2:0]     fsm_state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = PW + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] FULL      = NW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          rx_meta, rxs;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push, stop_bad;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          ack_q;
    logic          full, pop, accept;

    // Receiver: synchroniser and FSM registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        stop_bad = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    // Start bit still low at mid-bit: a real frame, not a glitch
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new start bit is recognised
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fsm_state = state_q;

    // FIFO: a pop in the same cycle makes room for a push into a full buffer
    assign full   = (count == FULL);
    assign pop    = cpu.ack & ~ack_q & (count != '0);
    assign accept = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ack_q     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ack_q <= cpu.ack;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (push && !accept) overrun   <= 1'b1;
            if (stop_bad)        frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= shift_q;
    end

    assign cpu.irr    = (count != '0);
    assign cpu.r_data = (count != '0) ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_intr.sv
// Bench for uart_rx_intr: bit-banged frames, a queue model of the FIFO, and an ack-edge monitor.
module tb_uart_rx_intr;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       overrun;
  logic       frame_err;
  logic [2:0] fsm_state;

  uart_rx_intr_if bus ();

  uart_rx_intr #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .cpu(bus),
    .overrun(overrun),
    .frame_err(frame_err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  bit         exp_overrun;
  bit         exp_frame_err;
  int         errors = 0;
  int         checks = 0;
  logic       ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: a frame with a good stop bit enters the buffer if there is room
  task automatic model_frame(input logic [7:0] data, input bit stop_ok);
    if (!stop_ok)                   exp_frame_err = 1'b1;
    else if (exp_q.size() < DEPTH)  exp_q.push_back(data);
    else                            exp_overrun = 1'b1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_overrun   = 1'b0;
    exp_frame_err = 1'b0;
  endtask

  // driver tasks
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                            input int low_after, input int abort_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == abort_bit) begin
        hold(CPB / 2);
        reset = 1'b1;
        rx    = 1'b1;
        hold(1);
        reset = 1'b0;
        model_reset();
        return;
      end
      hold(CPB);
    end
    rx = stop_ok;
    hold(CPB);
    if (!stop_ok) hold(low_after);
    rx = 1'b1;
    model_frame(data, stop_ok);
  endtask

  task automatic do_ack(input int len);
    @(posedge clk); #1;
    bus.ack = 1'b1;
    hold(len);
    bus.ack = 1'b0;
    hold(2);
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    @(negedge clk);
    head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    check({tag, "_irr"}, bus.irr, (exp_q.size() != 0));
    check({tag, "_r_data"}, bus.r_data, head);
    check({tag, "_overrun"}, overrun, exp_overrun);
    check({tag, "_frame_err"}, frame_err, exp_frame_err);
  endtask

  // monitor: the head byte must be on r_data when the CPU raises ack
  always @(negedge clk) begin
    if (!reset && bus.ack && !ack_prev) begin
      if (exp_q.size() != 0) begin
        check("ack_irr", bus.irr, 1);
        check("ack_r_data", bus.r_data, exp_q.pop_front());
      end else begin
        check("ack_empty_irr", bus.irr, 0);
      end
    end
    ack_prev = bus.ack;
  end

  initial begin
    int lat;
    logic [7:0] b;
    bit ok;
    reset   = 1'b1;
    rx      = 1'b1;
    bus.ack = 1'b0;
    model_reset();
    hold(3);
    reset = 1'b0;
    check_state("reset");

    // single frame and its latency from the start edge
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 0, -1);
      begin
        @(posedge clk); #1;
        while (!bus.irr && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    checks++;
    if (lat < 154 || lat > 157) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected 154..157", lat);
    end
    check_state("a5");
    do_ack(1);
    check_state("a5_popped");

    // back-to-back frames; a long ack pops only once
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    hold(2);
    check_state("two");
    do_ack(5);
    check_state("long_ack");
    do_ack(1);
    check_state("two_drained");

    // overflow of the buffer
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1);
    hold(2);
    check_state("overrun");
    for (int i = 0; i < 4; i++) do_ack(2);
    check_state("overrun_drained");

    // short low glitch is not a frame
    reset = 1'b1;
    hold(1);
    reset = 1'b0;
    model_reset();
    check_state("reset2");
    @(posedge clk); #1;
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(2 * CPB);
    check_state("glitch");

    // bad stop bit followed by a break, then a good frame
    send_frame(8'h3C, 1'b0, 3 * CPB, -1);
    hold(4);
    check_state("break");
    send_frame(8'h7E, 1'b1, 0, -1);
    hold(2);
    check_state("after_break");
    do_ack(1);

    // reset in the middle of a frame with bytes buffered
    send_frame(8'h33, 1'b1, 0, -1);
    send_frame(8'h44, 1'b1, 0, -1);
    send_frame(8'h99, 1'b1, 0, 4);
    check_state("mid_reset");
    hold(CPB);
    send_frame(8'h5A, 1'b1, 0, -1);
    hold(2);
    check_state("after_reset");
    do_ack(1);

    // randomized frames, stop errors and acks
    for (int n = 0; n < 16; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, $urandom_range(0, 2 * CPB), -1);
      hold($urandom_range(1, 20));
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 2)) do_ack($urandom_range(1, 4));
      end
      check_state("rand");
    end
    for (int i = 0; i <= DEPTH; i++) begin
      if (exp_q.size() != 0) do_ack(1);
    end
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_intr.md
Name: uart_rx_intr

Overview:
Serial receive front-end that feeds the CPU's interrupt-request/read-data inputs (irr, r_data, ack). It deserialises 8N1 UART frames from an asynchronous rx pin and buffers received bytes in a small FIFO. It presents the head byte with irr held high while the FIFO is non-empty, and pops one byte per acknowledge. It is the input-side peer of the UART transmitter that consumes w_req/w_data and drives w_busy.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
irr  output  1  interrupt request; high while FIFO non-empty
r_data  output  8  FIFO head byte; 8'h00 when empty
ack  input  1  CPU acknowledge; level may be held for several cycles
overrun  output  1  sticky: byte dropped because FIFO full
frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (synchronous, active-high; clock clk): all of the following take effect on the next edge.
  - Synchroniser flops set to 1; FSM to IDLE; counters and FIFO pointers to 0.
  - irr=0, r_data=8'h00, overrun=0, frame_err=0, ack edge register=0.
  - Reset mid-frame discards the partial byte and all buffered bytes.
- rx passes through a 2-flop synchroniser; the FSM uses only the synchronised value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rxs==0 -> START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample rxs. If 0 -> DATA (counter cleared, bit index 0). If 1 -> IDLE (glitch, nothing recorded).
  - DATA: at count CLKS_PER_BIT-1, sample rxs into the shift register LSB-first and clear the counter. After bit index 7 -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rxs.
    - If 1: push the byte, then -> IDLE.
    - If 0: set frame_err, discard the byte, then -> BREAK.
  - BREAK: stay until rxs==1, then -> IDLE. A held-low line never generates spurious frames.
- Counter is a CLKS_PER_BIT-wide-enough binary counter. It wraps to 0 on each sample point, so samples fall mid-bit.
- FIFO:
  - Circular buffer with count register width $clog2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
  - Push when full is dropped and sets overrun. Exception: a pop in the same cycle frees a slot, so the push is accepted.
  - Pop event = ack & ~ack_q & (count!=0), where ack_q is ack registered. Exactly one byte is popped per ack rising edge regardless of pulse length. Ack while empty is ignored.
  - Simultaneous push and pop: both occur, count unchanged.
- Outputs:
  - irr = (count!=0), registered from the count register. It rises the cycle after the push edge and falls the cycle after the pop edge that empties the FIFO.
  - r_data = mem[rd_ptr] when count!=0, else 8'h00. It updates the cycle after a pop.
- Sticky flags clear only on reset.
- Latency: rx falling edge to irr high = 2 synchroniser cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1).

Test Plan:
- CLKS_PER_BIT=16. Send frame 0xA5 with a correct stop bit -> irr rises ~155 cycles after the start edge, r_data=8'hA5, overrun=0, frame_err=0. One-cycle ack -> irr=0, r_data=8'h00 next cycle.
- Send 0x11 then 0x22 back-to-back. Hold ack high for 5 cycles -> exactly one pop: r_data=8'h22, irr stays 1. Second ack rising edge -> irr=0.
- DEPTH=4: send 0x01..0x05 with no ack -> overrun=1 after the 5th stop bit. Then four ack edges read 0x01, 0x02, 0x03, 0x04; irr=0 after the fourth.
- rx low glitch for 4 cycles (less than CLKS_PER_BIT/2) -> FSM returns to IDLE, irr stays 0, no flags.
- Frame 0x3C with stop bit 0, then rx held low for 3 bit times, then high -> frame_err=1, no byte pushed. Next valid frame 0x7E -> r_data=8'h7E.
- Assert reset during DATA bit 4 with 2 bytes buffered -> next cycle irr=0, r_data=8'h00, flags 0. A following full frame 0x5A is received correctly.
